// File: rtl/dm_map_pkg.sv
// Data-memory map constants and dumper state encoding shared across the SoC wrapper.
package dm_map_pkg;
  localparam logic [15:0] ANSWER_START = 16'h9000;
  localparam logic [15:0] HALT_ADDR    = 16'hFFFC;
  localparam logic [7:0]  HALT_BYTE    = 8'hFF;

  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, SEND, DONE} dumper_state_e;
endpackage

// File: rtl/dm_result_dumper.sv
// Snoops the DM write port for the halt flag, then reads the result words back over the
// shared DM read port and streams them out (valid/ready) with a running checksum.
module dm_result_dumper
  import dm_map_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] ANSWER_START = ADDR_W'(dm_map_pkg::ANSWER_START),
  parameter int unsigned       WORD_COUNT   = 74,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(dm_map_pkg::HALT_ADDR),
  parameter logic [7:0]        HALT_BYTE    = dm_map_pkg::HALT_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        snoop_w_en,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [31:0]       snoop_wdata,
  input  logic              clear,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              dm_rd_en,
  output logic [ADDR_W-1:0] dm_rd_addr,
  input  logic [31:0]       dm_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [31:0]       checksum,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      IDX_W    = $clog2(WORD_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  dumper_state_e     state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [31:0]       checksum_q, checksum_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              bus_req_q, bus_req_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              halt_hit;
  logic              unused_snoop;

  // Address arithmetic wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
    logic [31:0] offset;
    offset = 32'(idx) << 2;
    return ADDR_W'(32'(ANSWER_START) + offset);
  endfunction

  assign halt_hit = snoop_w_en[0] && (snoop_addr == HALT_ADDR) &&
                    (snoop_wdata[7:0] == HALT_BYTE);
  assign unused_snoop = ^{snoop_w_en[3:1], snoop_wdata[31:8]};

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    checksum_d = checksum_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    case (state_q)
      IDLE: if (halt_hit) state_d = REQ;
      REQ:  if (bus_gnt) state_d = RD;
      // Losing the grant between words sends us back to re-request the same index.
      RD:   state_d = bus_gnt ? WAIT : REQ;
      WAIT: begin
        out_data_d = dm_rd_data;
        out_addr_d = word_addr(index_q);
        state_d    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          checksum_d = checksum_q + out_data_q;
          index_d    = index_q + 1'b1;
          if (index_q == LAST_IDX) state_d = DONE;
          else if (bus_gnt)        state_d = RD;
          else                     state_d = REQ;
        end
      end
      DONE: begin
        if (clear) begin
          index_d    = '0;
          checksum_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered decodes of the next state.
    rd_en_d     = (state_d == RD);
    rd_addr_d   = (state_d == RD) ? word_addr(index_d) : '0;
    bus_req_d   = (state_d == REQ) || (state_d == RD) || (state_d == WAIT) || (state_d == SEND);
    out_valid_d = (state_d == SEND);
    out_last_d  = (state_d == SEND) && (index_d == LAST_IDX);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      checksum_q  <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      checksum_q  <= checksum_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      bus_req_q   <= bus_req_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // The strobe is qualified by the live grant so the SRAM never sees a read it did not mux in.
  assign dm_rd_en   = rd_en_q & bus_gnt;
  assign dm_rd_addr = rd_addr_q;
  assign bus_req    = bus_req_q;
  assign busy       = bus_req_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_last   = out_last_q;
  assign checksum   = checksum_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dm_result_dumper.sv
// Directed + randomized bench for dm_result_dumper with a DM SRAM model and a
// spec-level expectation of the dumped words, addresses and checksum.
module tb_dm_result_dumper;
  localparam int WC = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  snoop_w_en;
  logic [15:0] snoop_addr;
  logic [31:0] snoop_wdata;
  logic        clear;
  logic        bus_req;
  logic        bus_gnt;
  logic        dm_rd_en;
  logic [15:0] dm_rd_addr;
  logic [31:0] dm_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_addr;
  logic        out_last;
  logic [31:0] checksum;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:16383];

  dm_result_dumper #(
    .ADDR_W(16), .ANSWER_START(16'h9000), .WORD_COUNT(WC),
    .HALT_ADDR(16'hFFFC), .HALT_BYTE(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .snoop_w_en(snoop_w_en), .snoop_addr(snoop_addr),
    .snoop_wdata(snoop_wdata), .clear(clear), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .dm_rd_en(dm_rd_en), .dm_rd_addr(dm_rd_addr), .dm_rd_data(dm_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .checksum(checksum),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DM SRAM: one-cycle read latency.
  initial dm_rd_data = 32'h0;
  always @(posedge clk) if (dm_rd_en) dm_rd_data <= mem[dm_rd_addr[15:2]];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input int k);
    return 16'h9000 + 16'(4 * k);
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    logic [15:0] a;
    a = exp_addr(k);
    return mem[a[15:2]];
  endfunction

  task automatic snoop_write(input logic [3:0] en, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    snoop_w_en = en; snoop_addr = a; snoop_wdata = d;
    @(negedge clk);
    snoop_w_en = 4'h0; snoop_addr = 16'h0; snoop_wdata = 32'h0;
  endtask

  task automatic clear_pulse();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    #1;
    check("clear_done", done, 1'b0);
    check("clear_checksum", checksum, 32'h0);
    check("clear_busy", busy, 1'b0);
  endtask

  // gnt_mode/rdy_mode: 0 = held high, 1 = random; rdy_mode 2 = stall word 2 for 3 cycles.
  task automatic run_dump(input int gnt_mode, input int rdy_mode, input bit clr_noise,
                          input int budget, input int abort_at, output bit aborted);
    int k, cyc, last_acc, stall_cnt;
    logic [31:0] sum, held_d;
    logic [15:0] held_a;
    bit prev_stall;
    k = 0; cyc = 0; last_acc = -1; stall_cnt = 0; sum = 0;
    prev_stall = 0; held_d = 0; held_a = 0; aborted = 0;
    while (k < WC && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus_gnt = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      clear   = clr_noise ? ($urandom_range(0, 5) == 0) : 1'b0;
      if (abort_at >= 0 && out_valid && k == abort_at) begin
        aborted = 1;
        clear = 1'b0;
        return;
      end
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else begin
        out_ready = !(out_valid && k == 1 && stall_cnt < 3);
        if (!out_ready) stall_cnt++;
      end
      #1;
      if (dm_rd_en) begin
        check("rd_addr", dm_rd_addr, exp_addr(k));
        check("rd_while_req", bus_req, 1'b1);
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_d);
        check("hold_addr", out_addr, held_a);
      end
      if (out_valid && out_ready) begin
        check("word_data", out_data, exp_word(k));
        check("word_addr", out_addr, exp_addr(k));
        check("word_last", out_last, (k == WC - 1));
        check("checksum_run", checksum, sum);
        if (gnt_mode == 0 && rdy_mode == 0 && last_acc >= 0)
          check("throughput", cyc - last_acc, 3);
        last_acc = cyc;
        sum += exp_word(k);
        k++;
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_a = out_addr;
    end
    if (rdy_mode == 2) check("stall_cycles", stall_cnt, 3);
    if (k < WC) check("dump_timeout", k, WC);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_bus_req", bus_req, 1'b0);
    check("end_valid", out_valid, 1'b0);
    check("end_checksum", checksum, sum);
  endtask

  initial begin
    bit ab;
    rst = 1'b0; clear = 1'b0; snoop_w_en = 4'h0; snoop_addr = 16'h0; snoop_wdata = 32'h0;
    bus_gnt = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < WC; i++) mem[14'h2400 + 14'(i)] = 32'(i + 1);

    repeat (3) @(negedge clk);
    #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_checksum", checksum, 32'h0);
    check("rst_rd_en", dm_rd_en, 1'b0);
    rst = 1'b1;

    // Non-matching halt writes from IDLE.
    bus_gnt = 1'b1;
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FE); #1 check("bad_value", bus_req, 1'b0);
    snoop_write(4'b0001, 16'hFFF8, 32'h0000_00FF); #1 check("bad_addr", bus_req, 1'b0);
    snoop_write(4'b0010, 16'hFFFC, 32'h0000_00FF); #1 check("bad_lane", bus_req, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("bad_busy", busy, 1'b0);

    // Basic dump, continuous grant and ready.
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    #1 check("halt_latency", bus_req, 1'b1);
    run_dump(0, 0, 0, 200, -1, ab);
    check("t1_checksum", checksum, 32'h0000_000A);

    // Halt writes while DONE are ignored; done holds.
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    #1;
    check("done_halt_ignored", bus_req, 1'b0);
    check("done_held", done, 1'b1);

    // Re-arm and repeat.
    clear_pulse();
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    run_dump(0, 0, 0, 200, -1, ab);
    check("t6_checksum", checksum, 32'h0000_000A);

    // Backpressure on word 2.
    clear_pulse();
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    run_dump(0, 2, 0, 200, -1, ab);
    check("t3_checksum", checksum, 32'h0000_000A);

    // Grant delayed 5 cycles.
    clear_pulse();
    bus_gnt = 1'b0; out_ready = 1'b0;
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("nogrant_rd_en", dm_rd_en, 1'b0);
      check("nogrant_req", bus_req, 1'b1);
      @(negedge clk);
    end
    bus_gnt = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      #1;
      if (j == 1) begin
        check("gnt_rd_en", dm_rd_en, 1'b1);
        check("gnt_rd_addr", dm_rd_addr, 16'h9000);
      end
      check("gnt_to_valid", out_valid, (j == 3));
    end
    run_dump(0, 0, 0, 200, -1, ab);

    // Reset while word 2 is in SEND, then restart from scratch.
    clear_pulse();
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    run_dump(0, 0, 0, 200, 1, ab);
    check("abort_reached", ab, 1'b1);
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req", bus_req, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_checksum", checksum, 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_addr", out_addr, 16'h0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_rd_en", dm_rd_en, 1'b0);
    check("mid_rst_rd_addr", dm_rd_addr, 16'h0);
    rst = 1'b1;
    snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
    run_dump(0, 0, 0, 200, -1, ab);

    // Random data with random grant/ready and stray clear pulses mid-dump.
    for (int r = 0; r < 4; r++) begin
      clear_pulse();
      for (int i = 0; i < WC; i++) mem[14'h2400 + 14'(i)] = $urandom;
      snoop_write(4'b0001, 16'hFFFC, 32'h0000_00FF);
      run_dump(1, 1, 1, 600, -1, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
